// File: rtl/rr_mux_pkg.sv
// Shared constants and helpers for the round-robin handshake mux.
package rr_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic int sel_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_mux_if.sv
// Producer-side and consumer-side handshake bundle of rr_mux.
interface rr_mux_if
    import rr_mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int SEL_W = sel_width(N)
);

    logic [N-1:0]     in_valid;
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_ready;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic [SEL_W-1:0] out_sel;
    logic             out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );

endinterface

// File: rtl/rr_mux_arbiter.sv
// Combinational arbiter: searches upward from ptr (round-robin) or from 0 (fixed priority).
module rr_arbiter
    import rr_mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int SEL_W = sel_width(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [SEL_W-1:0] ptr_i,
    input  logic             mode_i,
    output logic [N-1:0]     gnt_o,
    output logic [SEL_W-1:0] gnt_idx_o,
    output logic             any_o
);

    int   start;
    int   idx;
    logic found;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_o     = |req_i;
        found     = 1'b0;
        idx       = 0;
        start     = (mode_i == MODE_RR) ? int'(ptr_i) : 0;
        for (int k = 0; k < N; k++) begin
            idx = (start + k) % N;
            if (!found && req_i[idx]) begin
                found          = 1'b1;
                gnt_o[idx]     = 1'b1;
                gnt_idx_o      = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/rr_mux.sv
// N-channel valid/ready mux with internal arbitration and a registered output stage.
module rr_mux
    import rr_mux_pkg::*;
#(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int RR = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    rr_mux_if.slave   bus
);

    localparam int   SEL_W = sel_width(N);
    localparam logic MODE  = (RR != 0) ? MODE_RR : MODE_FIXED;

    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_sel_q,   out_sel_d;
    logic [SEL_W-1:0] ptr_q,       ptr_d;

    logic [N-1:0]     gnt;
    logic [SEL_W-1:0] gnt_idx;
    logic             any_req;
    logic             load;
    logic [N-1:0]     in_ready;

    rr_arbiter #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_arbiter (
        .req_i     (bus.in_valid),
        .ptr_i     (ptr_q),
        .mode_i    (MODE),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .any_o     (any_req)
    );

    // The output register can take a beat when empty or being drained this cycle.
    always_comb begin
        load        = !out_valid_q || bus.out_ready;
        in_ready    = '0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (rst_n && load) begin
            in_ready    = gnt;
            out_valid_d = any_req;
            if (any_req) begin
                out_data_d = bus.in_data[gnt_idx*W +: W];
                out_sel_d  = gnt_idx;
                if (MODE == MODE_RR) begin
                    ptr_d = (gnt_idx == SEL_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux.sv
// Directed checks of rr_mux in round-robin (bm/dut_rr) and fixed-priority (bf/dut_fp) modes.
module tb_rr_mux;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    rr_mux_if #(.N(4), .W(8)) bm ();
    rr_mux_if #(.N(4), .W(8)) bf ();

    rr_mux #(.N(4), .W(8), .RR(1)) dut_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bm.slave)
    );

    rr_mux #(.N(4), .W(8), .RR(0)) dut_fp (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Waits for the next rising edge, then samples registered outputs 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bm.in_valid  = 4'hF;
        bm.out_ready = 1'b1;
        step();
        step();
        checks++;
        if (bm.out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_out_valid: got %0b expected 0", bm.out_valid);
        end
        checks++;
        if (bm.out_data !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_out_data: got %0h expected 00", bm.out_data);
        end
        checks++;
        if (bm.out_sel !== 2'd0) begin
            failures++;
            $display("[TB] FAIL reset_out_sel: got %0d expected 0", bm.out_sel);
        end
        checks++;
        if (bm.in_ready !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_in_ready: got %b expected 0000", bm.in_ready);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (bm.in_ready !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL reset_release_in_ready: got %b expected 0001", bm.in_ready);
        end
        step();
        checks++;
        if (bm.out_valid !== 1'b1 || bm.out_sel !== 2'd0 || bm.out_data !== 8'h10) begin
            failures++;
            $display("[TB] FAIL reset_first_capture: got v=%0b sel=%0d data=%0h expected v=1 sel=0 data=10",
                     bm.out_valid, bm.out_sel, bm.out_data);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] expSel [4];
        logic [7:0] expData [4];
        expSel  = '{2'd1, 2'd2, 2'd3, 2'd0};
        expData = '{8'h11, 8'h12, 8'h13, 8'h10};
        checks++;
        if (bm.in_ready !== 4'b0010) begin
            failures++;
            $display("[TB] FAIL rr_in_ready: got %b expected 0010", bm.in_ready);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (bm.out_valid !== 1'b1 || bm.out_sel !== expSel[i] || bm.out_data !== expData[i]) begin
                failures++;
                $display("[TB] FAIL rr_cycle%0d: got v=%0b sel=%0d data=%0h expected v=1 sel=%0d data=%0h",
                         i, bm.out_valid, bm.out_sel, bm.out_data, expSel[i], expData[i]);
            end
        end
    endtask

    task automatic test_stall();
        bm.out_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bm.in_ready !== 4'b0000) begin
                failures++;
                $display("[TB] FAIL stall_in_ready%0d: got %b expected 0000", i, bm.in_ready);
            end
            step();
            checks++;
            if (bm.out_valid !== 1'b1 || bm.out_sel !== 2'd0 || bm.out_data !== 8'h10) begin
                failures++;
                $display("[TB] FAIL stall_hold%0d: got v=%0b sel=%0d data=%0h expected v=1 sel=0 data=10",
                         i, bm.out_valid, bm.out_sel, bm.out_data);
            end
        end
        bm.out_ready = 1'b1;
        step();
        checks++;
        if (bm.out_sel !== 2'd1 || bm.out_data !== 8'h11) begin
            failures++;
            $display("[TB] FAIL stall_release: got sel=%0d data=%0h expected sel=1 data=11",
                     bm.out_sel, bm.out_data);
        end
    endtask

    task automatic test_sparse_wrap();
        bm.in_valid = 4'b1010;
        #1;
        checks++;
        if (bm.in_ready !== 4'b1000) begin
            failures++;
            $display("[TB] FAIL sparse_in_ready: got %b expected 1000", bm.in_ready);
        end
        step();
        checks++;
        if (bm.out_sel !== 2'd3 || bm.out_data !== 8'h13) begin
            failures++;
            $display("[TB] FAIL sparse_grant3: got sel=%0d data=%0h expected sel=3 data=13",
                     bm.out_sel, bm.out_data);
        end
        step();
        checks++;
        if (bm.out_sel !== 2'd1 || bm.out_data !== 8'h11) begin
            failures++;
            $display("[TB] FAIL sparse_wrap_grant1: got sel=%0d data=%0h expected sel=1 data=11",
                     bm.out_sel, bm.out_data);
        end
    endtask

    task automatic test_idle();
        bm.in_valid = 4'b0000;
        step();
        checks++;
        if (bm.out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL idle_out_valid: got %0b expected 0", bm.out_valid);
        end
        bm.in_valid = 4'hF;
        step();
        checks++;
        if (bm.out_valid !== 1'b1 || bm.out_sel !== 2'd2 || bm.out_data !== 8'h12) begin
            failures++;
            $display("[TB] FAIL idle_ptr_kept: got v=%0b sel=%0d data=%0h expected v=1 sel=2 data=12",
                     bm.out_valid, bm.out_sel, bm.out_data);
        end
    endtask

    task automatic test_fixed_priority();
        bf.in_valid  = 4'b0110;
        bf.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bf.out_valid !== 1'b1 || bf.out_sel !== 2'd1 || bf.out_data !== 8'hA1) begin
                failures++;
                $display("[TB] FAIL fixed_prio%0d: got v=%0b sel=%0d data=%0h expected v=1 sel=1 data=a1",
                         i, bf.out_valid, bf.out_sel, bf.out_data);
            end
        end
        bf.in_valid = 4'b0100;
        step();
        checks++;
        if (bf.out_sel !== 2'd2 || bf.out_data !== 8'hA2) begin
            failures++;
            $display("[TB] FAIL fixed_after_drop: got sel=%0d data=%0h expected sel=2 data=a2",
                     bf.out_sel, bf.out_data);
        end
        bf.in_valid = 4'b0000;
    endtask

    task automatic test_reset_midstream();
        bm.in_valid = 4'hF;
        step();
        checks++;
        if (bm.out_valid !== 1'b1 || bm.out_sel !== 2'd3) begin
            failures++;
            $display("[TB] FAIL midrst_pre: got v=%0b sel=%0d expected v=1 sel=3", bm.out_valid, bm.out_sel);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bm.out_valid !== 1'b0 || bm.out_data !== 8'h00 || bm.in_ready !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL midrst_async: got v=%0b data=%0h rdy=%b expected v=0 data=00 rdy=0000",
                     bm.out_valid, bm.out_data, bm.in_ready);
        end
        #2;
        rst_n = 1'b1;
        step();
        checks++;
        if (bm.out_valid !== 1'b1 || bm.out_sel !== 2'd0 || bm.out_data !== 8'h10) begin
            failures++;
            $display("[TB] FAIL midrst_restart: got v=%0b sel=%0d data=%0h expected v=1 sel=0 data=10",
                     bm.out_valid, bm.out_sel, bm.out_data);
        end
        step();
        checks++;
        if (bm.out_sel !== 2'd1 || bm.out_data !== 8'h11) begin
            failures++;
            $display("[TB] FAIL midrst_next: got sel=%0d data=%0h expected sel=1 data=11",
                     bm.out_sel, bm.out_data);
        end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        bm.in_valid  = '0;
        bm.in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
        bm.out_ready = 1'b0;
        bf.in_valid  = '0;
        bf.in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        bf.out_ready = 1'b0;
        #1;
        test_reset();
        test_round_robin();
        test_stall();
        test_sparse_wrap();
        test_idle();
        test_fixed_priority();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_mux.md
# rr_mux

Parametrised N-channel, W-bit multiplexer with valid/ready handshaking on every channel and a registered output stage. Successor to the plain 2:1 select mux. Channel choice comes from an internal arbiter (round-robin or fixed priority), not an external `sel`. It sits between several producers and a single consumer and accepts at most one beat per cycle.

## Interface
- `N`, 4: number of input channels, N ≥ 2.
- `W`, 8: data width per channel, W ≥ 1.
- `RR`, 1: arbitration mode. 1 = round-robin, 0 = fixed priority (lowest index wins).
- `SEL_W`, derived: max(1, clog2(N)). Not user-set.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, N: per-channel valid. Bit i belongs to channel i.
- `in_data`, in, N*W: channel i occupies bits [i*W +: W].
- `in_ready`, out, N: per-channel ready. At most one bit is high in any cycle.
- `out_valid`, out, 1: output register holds a beat.
- `out_data`, out, W: registered data.
- `out_sel`, out, SEL_W: index of the channel that supplied `out_data`.
- `out_ready`, in, 1: consumer accepts the beat.

## Operation
- `load = !out_valid || out_ready`. This is the output register's capacity to take a new beat this cycle.
- Grant:
  - Computed combinationally from `in_valid` and pointer `ptr` (SEL_W bits).
  - RR=1: first asserted `in_valid` searching upward from `ptr` with wrap-around.
  - RR=0: lowest-index asserted `in_valid`; `ptr` is unused and stays 0.
- `in_ready[g] = load && in_valid[g]` for granted channel g. All other `in_ready` bits are 0. If no `in_valid` bit is set, all `in_ready` bits are 0.
- Transfer on channel g means `in_valid[g] && in_ready[g]`. On that clock edge:
  - `out_data` ← channel g data.
  - `out_sel` ← g.
  - `out_valid` ← 1.
  - RR=1 only: `ptr` ← (g+1) mod N, so `ptr` wraps from N-1 to 0.
- If `load` is high and no channel is valid: `out_valid` ← 0. `out_data` and `out_sel` hold their previous values, which are don't-care.
- If `load` is low (stall): `out_valid`, `out_data`, `out_sel` and `ptr` all hold, and all `in_ready` bits are 0.
- `ptr` changes only on a transfer. Idle cycles and stalls never move it.
- Consumer accept and new capture in the same cycle (`out_valid && out_ready` with a valid input): the new beat replaces the old one, with no bubble.

## Timing
- Latency: 1 cycle from input transfer to `out_valid`/`out_data`.
- Throughput: 1 beat per cycle while `out_ready` is held high.
- Reset values:
  - `out_valid` = 0, `out_data` = 0, `out_sel` = 0, `ptr` = 0.
  - `in_ready` is all 0 while `rst_n` is low (gated combinationally).
- Reset mid-operation:
  - Asserting `rst_n` clears the registers immediately, asynchronously, and drops any held beat.
  - First possible transfer is on the first rising edge after `rst_n` deasserts.
- Round-robin fairness: with all N channels continuously valid and `out_ready` = 1, grants follow 0,1,…,N-1,0,…
- No combinational path from `in_data` to any output.
- Combinational paths `in_valid`/`out_ready` → `in_ready` are permitted. The consumer must not make `out_ready` depend on `in_ready`.

## Structure
- Shared package `rr_mux_pkg`:
  - constants `MODE_FIXED` = 0 and `MODE_RR` = 1;
  - function `sel_width(n)` returning max(1, clog2(n)).
- Sub-module `rr_arbiter`: purely combinational.
  - Inputs: `req[N]`, `ptr`, mode.
  - Outputs: one-hot `gnt[N]`, `gnt_idx`, `any`.
- `rr_mux` owns the pointer register, the output register and the handshake logic.

## Test plan
- Reset: hold `rst_n`=0 with all `in_valid`=1. Then `out_valid`=0, `out_data`=0, `out_sel`=0 and `in_ready`=0. Release reset: the first edge captures channel 0.
- Round-robin, N=4, W=8, RR=1: all channels valid with data 0x10,0x11,0x12,0x13 and `out_ready`=1.
  - `out_sel` must read 0,1,2,3,0 on consecutive cycles.
  - `out_data` must match the selected channel each cycle.
- Stall: `out_ready`=0 for 3 cycles while `out_valid`=1.
  - `out_data`/`out_sel` hold.
  - `in_ready` stays all 0.
  - `ptr` does not advance; the next grant after release is unchanged.
- Sparse and wrap-around: only channels 3 and 1 valid, with `ptr` = 2.
  - Grant channel 3, then `ptr` wraps to 0.
  - Grant channel 1 next.
- Fixed priority, RR=0: channels 1 and 2 always valid, so `out_sel` = 1 every cycle. Channel 2 is granted only after channel 1 deasserts `in_valid`.
- Reset mid-stream: assert `rst_n`=0 between clock edges while `out_valid`=1.
  - `out_valid` drops immediately.
  - After release, `ptr` = 0 and arbitration restarts at channel 0.
